hilo_muldiv: RTL and testbench

Execute-stage unit that consumes 5-bit ALU control codes for the HI/LO class of instructions (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO) and owns the HI/LO architectural registers. Multiplies complete in one cycle. Divides run on an iterative radix-2 restoring divider that stalls the pipeline until the quotient and remainder are written. It sits beside the main ALU in the E stage, fed by the same control code and rs/rt operands.

---
 rtl/hilo_muldiv_pkg.sv | 31 +++
 rtl/hilo_muldiv_div.sv | 83 ++++++++
 rtl/hilo_muldiv.sv | 145 ++++++++++++++
 tb/tb_hilo_muldiv.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_pkg
// Description : Shared constants for the HI/LO multiply/divide unit. It holds
//               the ALU control codes for the HI/LO instruction class, the
//               datapath widths and a magnitude/negate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  // HI/LO-class ALU control codes (shared with the main ALU decoder)
  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;
  localparam logic [4:0] MFHI_CONTROL  = 5'b11100;
  localparam logic [4:0] MTHI_CONTROL  = 5'b11101;
  localparam logic [4:0] MFLO_CONTROL  = 5'b11110;
  localparam logic [4:0] MTLO_CONTROL  = 5'b11111;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_div.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2
// Description : Unsigned iterative radix-2 restoring divider, one quotient bit
//               per cycle, 32 iterations.
//   clk, rst        : clock, synchronous active-high reset
//   start_i         : load dividend/divisor and begin iterating
//   abort_i         : cancel an in-flight divide, clear the counter
//   dividend_i      : unsigned dividend (sampled on start)
//   divisor_i       : unsigned divisor (sampled on start)
//   done_o          : high during the final iteration cycle
//   quotient_o      : quotient, valid the cycle after done_o
//   remainder_o     : remainder, valid the cycle after done_o
// Revision    : 1.0 - initial release
// ============================================================================
module div_radix2
  import hilo_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  logic              borrow;
  logic [DATA_W-1:0] diff;
  logic              take;

  // The partial remainder is always below the divisor, so when its top bit
  // is set the shifted value exceeds any 32-bit divisor: subtraction is
  // guaranteed and the true difference still fits in 32 bits. That lets a
  // single 33-bit subtractor cover the shifted {rem, next dividend bit}.
  assign {borrow, diff} = {1'b0, rem_q[DATA_W-2:0], quo_q[DATA_W-1]} - {1'b0, dvs_q};
  assign take = rem_q[DATA_W-1] | ~borrow;

  always_comb begin
    rem_d = take ? diff : {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
    quo_d = {quo_q[DATA_W-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o      = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : E-stage HI/LO unit. It executes MULT/MULTU in one cycle,
//               MTHI/MTLO/MFHI/MFLO, and DIV/DIVU on an iterative divider that
//               stalls the pipeline. It owns the HI and LO registers.
//   clk, rst      : clock, synchronous active-high reset
//   valid_i       : E-stage instruction is live
//   alucontrol_i  : ALU control code (non HI/LO codes are no-ops)
//   a_i, b_i      : rs / rt operands
//   flush_i       : cancel current op, suppress any HI/LO write this cycle
//   stall_o       : hold E and earlier stages
//   result_o      : MFHI/MFLO read value, else 0
//   hi_o, lo_o    : architectural HI / LO
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [4:0]        alucontrol_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              qneg_q, rneg_q, dbz_q;
  logic [DATA_W-1:0] araw_q;

  logic              accept, is_div, is_sdiv, div_start, div_abort, div_done;
  logic              sa, sb;
  logic [DATA_W-1:0] quo, rem;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;

  assign accept    = valid_i && !flush_i && (state_q == S_IDLE);
  assign is_sdiv   = (alucontrol_i == DIV_CONTROL);
  assign is_div    = is_sdiv || (alucontrol_i == DIVU_CONTROL);
  assign div_start = accept && is_div;
  assign div_abort = (state_q == S_BUSY) && flush_i;

  assign sa = is_sdiv & a_i[DATA_W-1];
  assign sb = is_sdiv & b_i[DATA_W-1];

  assign prod_s = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) *
                  $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
  assign prod_u = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

  div_radix2 u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .abort_i     (div_abort),
    .dividend_i  (cond_neg(a_i, sa)),
    .divisor_i   (cond_neg(b_i, sb)),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (div_start) state_d = S_BUSY;
      S_BUSY: begin
        if (flush_i)       state_d = S_IDLE;
        else if (div_done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (accept) begin
      unique case (alucontrol_i)
        MULT_CONTROL:  {hi_d, lo_d} = prod_s;
        MULTU_CONTROL: {hi_d, lo_d} = prod_u;
        MTHI_CONTROL:  hi_d = a_i;
        MTLO_CONTROL:  lo_d = a_i;
        default: ;
      endcase
    end else if ((state_q == S_DONE) && !flush_i) begin
      if (dbz_q) begin
        // Divide-by-zero leaves the dividend in HI and all-ones in LO.
        hi_d = araw_q;
        lo_d = '1;
      end else begin
        hi_d = cond_neg(rem, rneg_q);
        lo_d = cond_neg(quo, qneg_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      araw_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (div_start) begin
        qneg_q <= sa ^ sb;
        rneg_q <= sa;
        dbz_q  <= (b_i == '0);
        araw_q <= a_i;
      end
    end
  end

  assign stall_o  = div_start || ((state_q == S_BUSY) && !flush_i);
  assign result_o = (alucontrol_i == MFHI_CONTROL) ? hi_q :
                    (alucontrol_i == MFLO_CONTROL) ? lo_q : '0;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv
// Description : Self-checking bench for hilo_muldiv. Directed scenarios plus
//               random HI/LO-class operations compared to an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam logic [4:0] NOP_CONTROL = 5'b00010;

  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [4:0]  ctl;
  logic [31:0] a, b;
  logic        stall;
  logic [31:0] result, hi, lo;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid),
    .alucontrol_i (ctl),
    .a_i          (a),
    .b_i          (b),
    .flush_i      (flush),
    .stall_o      (stall),
    .result_o     (result),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_div(input logic [4:0] c);
    return (c == DIV_CONTROL) || (c == DIVU_CONTROL);
  endfunction

  // Architectural effect of one completed instruction, in plain arithmetic.
  task automatic model_op(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    case (c)
      MULT_CONTROL: begin
        p = longint'($signed(x)) * longint'($signed(y));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      MULTU_CONTROL: begin
        p = {32'b0, x} * {32'b0, y};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      MTHI_CONTROL: m_hi = x;
      MTLO_CONTROL: m_lo = x;
      DIV_CONTROL, DIVU_CONTROL: begin
        if (y == 32'd0) begin
          m_hi = x; m_lo = 32'hFFFFFFFF;
        end else begin
          if (c == DIV_CONTROL) begin
            sx = {{32{x[31]}}, x}; sy = {{32{y[31]}}, y};
          end else begin
            sx = {32'b0, x}; sy = {32'b0, y};
          end
          q = sx / sy;
          r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      default: ;
    endcase
  endtask

  // Issue one instruction, hold it while stalled, then check HI/LO.
  task automatic run_op(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                        input int exp_stall, input string tag);
    int cnt;
    logic [31:0] exp_res;
    exp_res = (c == MFHI_CONTROL) ? m_hi : (c == MFLO_CONTROL) ? m_lo : 32'd0;
    @(negedge clk);
    valid = 1'b1; ctl = c; a = x; b = y;
    #1;
    check_val({tag, " result"}, result, exp_res);
    cnt = 0;
    while (stall && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    check_val({tag, " stall cycles"}, 32'(cnt), 32'(exp_stall));
    @(posedge clk);
    model_op(c, x, y);
    @(negedge clk);
    valid = 1'b0; ctl = NOP_CONTROL;
    #1;
    check_val({tag, " hi"}, hi, m_hi);
    check_val({tag, " lo"}, lo, m_lo);
  endtask

  initial begin
    logic [4:0]  codes [9];
    logic [4:0]  c;
    logic [31:0] x, y;

    codes = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL, MFHI_CONTROL,
              MTHI_CONTROL, MFLO_CONTROL, MTLO_CONTROL, NOP_CONTROL};
    rst = 1'b1; valid = 1'b0; flush = 1'b0; ctl = NOP_CONTROL; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset hi", hi, 32'd0);
    check_val("reset lo", lo, 32'd0);
    check_val("reset stall", 32'(stall), 32'd0);
    check_val("reset result", result, 32'd0);
    rst = 1'b0;

    // Moves and reads
    run_op(MTHI_CONTROL, 32'h12345678, 32'd0, 0, "mthi");
    run_op(MTLO_CONTROL, 32'h9ABCDEF0, 32'd0, 0, "mtlo");
    run_op(MFHI_CONTROL, 32'd0, 32'd0, 0, "mfhi");
    run_op(MFLO_CONTROL, 32'd0, 32'd0, 0, "mflo");

    // Multiplies
    run_op(MULT_CONTROL,  32'hFFFFFFFE, 32'd3, 0, "mult");
    run_op(MULTU_CONTROL, 32'hFFFFFFFE, 32'd3, 0, "multu");

    // Divides including the divide-by-zero and overflow corner
    run_op(DIV_CONTROL,  32'hFFFFFFF9, 32'd2, 33, "div -7/2");
    run_op(DIVU_CONTROL, 32'd100, 32'd7, 33, "divu 100/7");
    run_op(DIVU_CONTROL, 32'h55, 32'd0, 33, "divu by zero");
    run_op(DIV_CONTROL,  32'h80000000, 32'hFFFFFFFF, 33, "div minint/-1");
    run_op(DIV_CONTROL,  32'h1234, 32'd0, 33, "div by zero");

    // Flush during BUSY
    @(negedge clk);
    valid = 1'b1; ctl = DIV_CONTROL; a = 32'd1000; b = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
    end
    #1;
    check_val("flush pre stall", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    check_val("flush stall drop", 32'(stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0; ctl = NOP_CONTROL;
    #1;
    check_val("flush hi kept", hi, m_hi);
    check_val("flush lo kept", lo, m_lo);
    run_op(MTLO_CONTROL, 32'hCAFEF00D, 32'd0, 0, "mtlo after flush");

    // Reset mid-division
    @(negedge clk);
    valid = 1'b1; ctl = DIV_CONTROL; a = 32'd5000; b = 32'd7;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; ctl = NOP_CONTROL;
    m_hi = '0; m_lo = '0;
    #1;
    check_val("rst mid-div stall", 32'(stall), 32'd0);
    check_val("rst mid-div hi", hi, 32'd0);
    check_val("rst mid-div lo", lo, 32'd0);
    run_op(DIVU_CONTROL, 32'hDEADBEEF, 32'd10, 33, "divu after rst");

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      c = codes[$urandom_range(0, 8)];
      x = $urandom;
      case ($urandom_range(0, 3))
        0:       y = $urandom;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'd0;
        default: y = 32'hFFFFFFFF;
      endcase
      if ($urandom_range(0, 4) == 0) x = 32'h80000000;
      run_op(c, x, y, is_div(c) ? 33 : 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
